// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants, scan state encoding and digit select helper
package display_pkg;

    localparam int         NUM_DIGITS = 6;
    localparam logic [3:0] BLANK_CODE = 4'hF;

    typedef enum logic {
        SHOW = 1'b0,
        GAP  = 1'b1
    } scan_state_t;

    function automatic logic [3:0] digit_at(input logic [23:0] digits, input logic [2:0] idx);
        return digits[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/refresh_tick.sv
// rtl/refresh_tick.sv - prescaler counting 0..DIV-1 while enabled, tick on the last count
module refresh_tick #(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;

    assign tick = en && (cnt_q == CW'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= tick ? '0 : cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/display_scan.sv
// rtl/display_scan.sv - six-digit multiplexed display scanner with frame-synchronous update
module display_scan
    import display_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] digits_in,
    input  logic        digits_valid,
    input  logic        blank_lead,
    output logic [3:0]  digit_out,
    output logic [5:0]  an,
    output logic        frame_done
);

    localparam int GW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

    scan_state_t   state_q, state_d;
    logic [2:0]    idx_q;
    logic [GW-1:0] gap_q;
    logic          tick;
    logic          gap_done;
    logic          advance;
    logic          wrap;
    logic          wrapped_q;
    logic [23:0]   shadow_q;
    logic [23:0]   pend_q;
    logic          pend_flag;
    logic [3:0]    cur_digit;
    logic [3:0]    shown_digit;

    refresh_tick #(.DIV(REFRESH_DIV)) u_refresh_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_q == SHOW),
        .tick  (tick)
    );

    assign gap_done = (state_q == GAP) && (gap_q == GW'(BLANK_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        advance = 1'b0;
        case (state_q)
            SHOW: begin
                if (tick) begin
                    if (BLANK_CYCLES > 0) state_d = GAP;
                    else                  advance = 1'b1;
                end
            end
            GAP: begin
                if (gap_done) begin
                    state_d = SHOW;
                    advance = 1'b1;
                end
            end
            default: state_d = SHOW;
        endcase
    end

    assign wrap = advance && (idx_q == 3'(NUM_DIGITS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SHOW;
            idx_q     <= '0;
            gap_q     <= '0;
            wrapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wrapped_q <= wrap;
            if (advance) idx_q <= wrap ? 3'd0 : idx_q + 3'd1;
            gap_q <= (state_q == GAP && !gap_done) ? gap_q + GW'(1) : '0;
        end
    end

    // Shadow only changes at the wrap edge so a frame never mixes old and new digits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q  <= '0;
            pend_q    <= '0;
            pend_flag <= 1'b0;
        end else if (wrap) begin
            if (digits_valid)   shadow_q <= digits_in;
            else if (pend_flag) shadow_q <= pend_q;
            pend_flag <= 1'b0;
        end else if (digits_valid) begin
            pend_q    <= digits_in;
            pend_flag <= 1'b1;
        end
    end

    assign cur_digit   = digit_at(shadow_q, idx_q);
    assign shown_digit = (idx_q == 3'(NUM_DIGITS - 1) && blank_lead && cur_digit == 4'd0)
                         ? BLANK_CODE : cur_digit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an         <= '1;
            digit_out  <= BLANK_CODE;
            frame_done <= 1'b0;
        end else begin
            frame_done <= wrapped_q;
            if (state_q == SHOW) begin
                an        <= ~(6'b000001 << idx_q);
                digit_out <= shown_digit;
            end else begin
                an        <= '1;
                digit_out <= BLANK_CODE;
            end
        end
    end

endmodule

// File: tb/tb_display_scan.sv
// tb/tb_display_scan.sv - bench for display_scan with a timing/data model and directed literal checks
module tb_display_scan;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] digits_in;
    logic        digits_valid;
    logic        blank_lead;
    logic [3:0]  dout0, dout1;
    logic [5:0]  an0, an1;
    logic        fd0, fd1;

    always #5 clk = ~clk;

    display_scan #(.REFRESH_DIV(4), .BLANK_CYCLES(2)) u0 (
        .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .digits_valid(digits_valid),
        .blank_lead(blank_lead), .digit_out(dout0), .an(an0), .frame_done(fd0)
    );

    display_scan #(.REFRESH_DIV(4), .BLANK_CYCLES(0)) u1 (
        .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .digits_valid(digits_valid),
        .blank_lead(blank_lead), .digit_out(dout1), .an(an1), .frame_done(fd1)
    );

    int vectors     = 0;
    int miscompares = 0;
    int t           = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, t);
        end
    endtask

    // Instance 0: 4 lit + 2 dark per digit; instance 1: 4 lit, no gap.
    function automatic int period(input int i);
        return (i == 0) ? 6 : 4;
    endfunction

    function automatic int frame_len(input int i);
        return 6 * period(i);
    endfunction

    logic [23:0] m_sh[2];
    logic [23:0] m_pd[2];
    bit          m_fl[2];
    logic [5:0]  e_an[2];
    logic [3:0]  e_d[2];
    logic        e_fd[2];

    always @(posedge clk) begin
        if (!rst_n) begin
            t = 0;
            for (int i = 0; i < 2; i++) begin
                m_sh[i] = '0; m_pd[i] = '0; m_fl[i] = 1'b0;
                e_an[i] = 6'h3F; e_d[i] = 4'hF; e_fd[i] = 1'b0;
            end
        end else begin
            t = t + 1;
            for (int i = 0; i < 2; i++) begin
                int k, w, d;
                logic [3:0] val;
                k = t - 1;
                w = k % frame_len(i);
                d = w / period(i);
                if ((w % period(i)) < 4) begin
                    val     = m_sh[i][4*d +: 4];
                    e_an[i] = ~(6'b000001 << d);
                    e_d[i]  = (d == 5 && blank_lead && val == 4'd0) ? 4'hF : val;
                end else begin
                    e_an[i] = 6'h3F;
                    e_d[i]  = 4'hF;
                end
                e_fd[i] = (w == 0) && (k > 0);
                // Inputs sampled at edge t land in the shadow if edge t+1 starts a new frame.
                if (t % frame_len(i) == 0) begin
                    if (digits_valid)  m_sh[i] = digits_in;
                    else if (m_fl[i])  m_sh[i] = m_pd[i];
                    m_fl[i] = 1'b0;
                end else if (digits_valid) begin
                    m_pd[i] = digits_in;
                    m_fl[i] = 1'b1;
                end
            end
        end
        #1;
        chk("model_an0", an0, e_an[0]);
        chk("model_digit0", dout0, e_d[0]);
        chk("model_frame_done0", fd0, e_fd[0]);
        chk("model_an1", an1, e_an[1]);
        chk("model_digit1", dout1, e_d[1]);
        chk("model_frame_done1", fd1, e_fd[1]);
    end

    task automatic wait_t(input int target);
        int n = 0;
        while (t != target && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (t != target) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_t timeout: got t=%0d expected t=%0d", t, target);
        end
    endtask

    task automatic strobe(input int edge_no, input logic [23:0] val);
        wait_t(edge_no - 1);
        digits_in    = val;
        digits_valid = 1'b1;
        @(negedge clk);
        digits_valid = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        digits_in    = '0;
        digits_valid = 1'b0;
        blank_lead   = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_an", an0, 6'h3F);
        chk("reset_digit", dout0, 4'hF);
        chk("reset_frame_done", fd0, 1'b0);
        rst_n = 1'b1;

        wait_t(1);
        chk("release_an", an0, 6'b111110);
        chk("release_digit", dout0, 4'd0);
        wait_t(5);
        chk("gap_dark_an", an0, 6'h3F);
        chk("nogap_digit1_an", an1, 6'b111101);

        strobe(10, 24'h123456);
        wait_t(11);
        chk("pending_set", u0.pend_flag, 1'b1);
        wait_t(36);
        chk("no_early_frame_done", fd0, 1'b0);
        chk("last_gap_digit", dout0, 4'hF);
        wait_t(37);
        chk("wrap_frame_done", fd0, 1'b1);
        chk("wrap_digit0", dout0, 4'd6);
        chk("wrap_an", an0, 6'b111110);
        wait_t(67);
        chk("new_digit5", dout0, 4'd1);
        chk("new_digit5_an", an0, 6'b011111);

        strobe(72, 24'h235959);
        wait_t(73);
        chk("coincide_digit0", dout0, 4'd9);
        chk("coincide_frame_done", fd0, 1'b1);
        chk("coincide_pending0", u0.pend_flag, 1'b0);
        chk("coincide_pending1", u1.pend_flag, 1'b0);
        chk("coincide_digit0_nogap", dout1, 4'd9);

        strobe(80, 24'h091500);
        wait_t(100);
        blank_lead = 1'b1;
        wait_t(103);
        chk("coincide_digit5", dout0, 4'd2);
        wait_t(139);
        chk("blank_lead_digit", dout0, 4'hF);
        chk("blank_lead_an", an0, 6'b011111);
        wait_t(150);
        blank_lead = 1'b0;
        wait_t(175);
        chk("no_blank_digit", dout0, 4'd0);
        chk("no_blank_an", an0, 6'b011111);

        wait_t(200);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midreset_an", an0, 6'h3F);
        chk("midreset_digit", dout0, 4'hF);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_t(1);
        chk("restart_an", an0, 6'b111110);
        chk("restart_digit", dout0, 4'd0);
        chk("restart_an_nogap", an1, 6'b111110);
        wait_t(5);
        chk("restart_nogap_digit1", dout1, 4'd0);
        wait_t(60);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/display_scan.md
DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000, clk cycles each digit is lit (range 2..2^20).
REQ-002 SHALL have parameter BLANK_CYCLES, default 16, all-anodes-off cycles between digits (0 = no gap).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port digits_in  input  24  six BCD digits; [3:0] = seconds units (digit 0) through [23:20] = hours tens (digit 5).
REQ-006 SHALL have port digits_valid  input  1  one-cycle strobe; digits_in is valid in that cycle.
REQ-007 SHALL have port blank_lead  input  1  1 = suppress hours-tens digit when it is 0.
REQ-008 SHALL have port digit_out  output  4  BCD code for the 7-segment decoder; 4'hF = blank.
REQ-009 SHALL have port an  output  6  digit enables, active-low, one-hot-low while lit.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse when digit 5 finishes and the scan wraps to digit 0.

Function
REQ-011 SHALL run a prescaler counting 0..REFRESH_DIV-1 during SHOW, producing tick on the last count, then clearing to 0.
REQ-012 SHALL implement FSM states SHOW and GAP; SHOW: an[idx]=0 for current idx, others 1; GAP: an=6'b111111, digit_out=4'hF.
REQ-013 SHALL transition SHOW->GAP on tick when BLANK_CYCLES>0, GAP->SHOW after exactly BLANK_CYCLES cycles with idx advanced; when BLANK_CYCLES=0, tick advances idx and stays in SHOW.
REQ-014 SHALL advance idx 0,1,2,3,4,5,0; wrap 5->0 asserts frame_done in the cycle the new idx 0 first drives outputs.
REQ-015 SHALL capture digits_in into a pending register with pending flag set on digits_valid; later strobe overwrites pending.
REQ-016 SHALL copy pending into the display shadow register only at frame wrap and clear the flag (no mid-frame tearing).
REQ-017 SHALL, if digits_valid coincides with the wrap cycle, load that cycle's digits_in directly into shadow and leave the flag clear.
REQ-018 SHALL drive digit_out = shadow digit[idx] in SHOW, except digit 5 drives 4'hF when blank_lead=1 and it equals 0 (an[5] still low).
REQ-019 SHALL pass non-BCD values (10..15) unchanged; blanking is left to the decoder.
REQ-020 SHALL register an, digit_out and frame_done; outputs change only on clk edges and never glitch.
REQ-021 SHALL never have more than one an bit low in any cycle.

Reset
REQ-022 SHALL, while rst_n=0: an=6'b111111, digit_out=4'hF, frame_done=0, state=SHOW, idx=0, prescaler=0, shadow=0, pending flag=0.
REQ-023 SHALL, on the first clk edge after rst_n deasserts, drive an=6'b111110, digit_out=shadow digit 0 (0).
REQ-024 SHALL abandon any in-progress digit or gap on mid-operation reset; no pending data survives.

Structure
REQ-025 SHALL place NUM_DIGITS=6, BLANK_CODE=4'hF and the SHOW/GAP state encoding in shared package display_pkg.
REQ-026 SHALL instantiate one sub-module refresh_tick (parameterized prescaler, tick output, synchronous enable) for REQ-011.
REQ-027 SHALL keep digit_out directly connectable to the decoder's 4-bit input; an drives board anodes directly.

Verification
REQ-028 SHALL check reset: rst_n low -> an=111111, digit_out=F; release -> an=111110, digit_out=0 next edge.
REQ-029 SHALL check scan timing with REFRESH_DIV=4, BLANK_CYCLES=2: each digit lit 4 cycles, 2 dark cycles, full frame = 36 cycles, frame_done once per 36.
REQ-030 SHALL check update latching: digits_valid with 24'h123456 mid-frame -> display unchanged until wrap, then digit 5=1 ... digit 0=6.
REQ-031 SHALL check coincidence: strobe 24'h235959 on the wrap cycle -> next frame shows 2,3,5,9,5,9 and pending flag 0.
REQ-032 SHALL check blanking: shadow 24'h091500, blank_lead=1 -> digit 5 outputs F with an[5]=0; blank_lead=0 -> outputs 0.
REQ-033 SHALL check BLANK_CYCLES=0 and mid-frame reset: no dark cycles between digits; reset at idx 3 -> restart at idx 0, shadow=0.
